periph_bus_arbiter: RTL and testbench
=====================================

PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, meaning the maximum number of consecutive accepted transfers per grant while the other master waits (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port reset, input, 1, the reset: synchronous and active-low.
REQ-004 SHALL have ports mN_req, input, 1, transfer request for master N (N = 0 CPU M-stage, N = 1 DMA).
REQ-005 SHALL have ports mN_addr, input, 32, byte address of the transfer.
REQ-006 SHALL have ports mN_wdata, input, 32, write data.
REQ-007 SHALL have ports mN_byteen, input, 4, byte enables; nonzero means write, zero means read.
REQ-008 SHALL have ports mN_gnt, output, 1, transfer accepted this cycle.
REQ-009 SHALL have ports mN_rvalid, output, 1, read data valid (one cycle after the accepted read).
REQ-010 SHALL have ports mN_rdata, output, 32, read data.
REQ-011 SHALL have ports s_addr / s_wdata, output, 32 each, the owner's address and data.
REQ-012 SHALL have port dm_byteen, output, 4, the data-memory byte enables.
REQ-013 SHALL have ports tc0_we / tc1_we, output, 1 each, the timer write strobes.
REQ-014 SHALL have ports dm_rdata / tc0_rdata / tc1_rdata, input, 32 each, the slave read data (DM data arrives one cycle after its address; timer data is combinational).
REQ-015 SHALL have port bus_err, output, 1, a one-cycle pulse for an access to an unmapped address.

Function
REQ-016 SHALL implement FSM states IDLE, OWN0, OWN1 as a registered state.
REQ-017 IDLE: SHALL go to OWN0 or OWN1 next cycle when any mN_req=1, using the arbitration policy (REQ-031/032); it SHALL grant nothing in IDLE (one-cycle arbitration latency).
REQ-018 OWNx: mx_gnt SHALL equal mx_req combinationally; the other master's gnt SHALL be 0.
REQ-019 The owner's addr, wdata and byteen SHALL be driven to the slaves only while mx_gnt=1; otherwise all strobes SHALL be 0.
REQ-020 Address decode: 0x0000-0x2FFF is DM; 0x7F00-0x7F0B is TC0; 0x7F10-0x7F1B is TC1; every other address is unmapped.
REQ-021 Write: dm_byteen=byteen for DM only; tcN_we=1 iff byteen!=0 and the address hits TCN; an unmapped write SHALL drop all strobes.
REQ-022 Burst counter: SHALL count accepted transfers in OWNx and clear on every state change.
REQ-023 When the count reaches MAX_BURST and the other master is requesting, SHALL move directly to the other OWN state.
REQ-024 If the owner deasserts req: SHALL go to the other OWN state if the other master is requesting, else to IDLE.
REQ-025 Accepted read: SHALL register the owner id and target; next cycle SHALL assert that master's rvalid with rdata muxed from the registered target.
REQ-026 Unmapped read: rdata SHALL be 0, with rvalid and bus_err both pulsed.
REQ-027 Writes SHALL never produce rvalid; an unmapped write SHALL pulse bus_err one cycle after acceptance.
REQ-028 A read accepted in the last cycle before an ownership switch SHALL still return its rvalid to the original master.

Reset
REQ-029 While reset=0 at a clock edge: state SHALL become IDLE, the burst counter 0, and the pending read/err flags cleared.
REQ-030 During reset all outputs SHALL be 0, and a pending rvalid or bus_err from before reset SHALL be dropped (reset mid-transfer).

Configuration
REQ-031 With macro PERIPH_ARB_RR_EN defined: the IDLE choice between two simultaneous requests SHALL be round-robin, favouring the master not granted most recently (a 1-bit last-owner register, reset to 1 so that M0 wins first).
REQ-032 Without PERIPH_ARB_RR_EN: M0 SHALL always win in IDLE; the MAX_BURST switch SHALL still apply.

Structure
REQ-033 Shared package SHALL hold the address-range constants (DM_LO/HI, TC0_LO/HI, TC1_LO/HI), the FSM state encoding and the target enum (TGT_DM, TGT_TC0, TGT_TC1, TGT_NONE).
REQ-034 One sub-module, periph_addr_decode (address -> target), SHALL be instantiated.

Verification
REQ-035 Reset released, m0 reads 0x0004 (DM returns 0x1234_5678): gnt in cycle 2, m0_rvalid=1 with rdata=0x12345678 in cycle 3.
REQ-036 m0 writes 0x7F04 with byteen=0xF, data 0xA5: tc0_we=1 and s_wdata=0xA5 in the gnt cycle; dm_byteen=0; tc1_we=0.
REQ-037 m1 reads 0x5000: m1_rvalid=1, rdata=0 and bus_err=1 for exactly one cycle; no strobes.
REQ-038 Both masters request continuously, MAX_BURST=4: pattern of 4 m0 grants, 4 m1 grants, repeating, with no idle cycle between bursts.
REQ-039 Both request from IDLE repeatedly, with req dropped after each transfer: alternating winners with RR_EN, always M0 without it.
REQ-040 reset=0 asserted in the cycle after an accepted DM read: no rvalid follows; state is IDLE; all outputs are 0.

Source files
------------

// File: rtl/periph_bus_arbiter_pkg.sv
// Shared types and address map for the two-master peripheral bus arbiter.
package periph_bus_arbiter_pkg;

    localparam logic [31:0] DM_LO  = 32'h0000_0000;
    localparam logic [31:0] DM_HI  = 32'h0000_2FFF;
    localparam logic [31:0] TC0_LO = 32'h0000_7F00;
    localparam logic [31:0] TC0_HI = 32'h0000_7F0B;
    localparam logic [31:0] TC1_LO = 32'h0000_7F10;
    localparam logic [31:0] TC1_HI = 32'h0000_7F1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        TGT_DM   = 2'd0,
        TGT_TC0  = 2'd1,
        TGT_TC1  = 2'd2,
        TGT_NONE = 2'd3
    } tgt_e;

    // One master's request bundle; byteen == 0 marks a read.
    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byteen;
    } mreq_t;

    function automatic logic in_range(input logic [31:0] a,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/periph_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the DM/timer slaves.
interface periph_bus_arbiter_if;
    logic        m0_req,    m1_req;
    logic [31:0] m0_addr,   m1_addr;
    logic [31:0] m0_wdata,  m1_wdata;
    logic [3:0]  m0_byteen, m1_byteen;
    logic        m0_gnt,    m1_gnt;
    logic        m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata,  m1_rdata;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  dm_byteen;
    logic        tc0_we;
    logic        tc1_we;
    logic [31:0] dm_rdata;
    logic [31:0] tc0_rdata;
    logic [31:0] tc1_rdata;
    logic        bus_err;

    // Arbiter side.
    modport slave (
        input  m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata,
               m0_byteen, m1_byteen, dm_rdata, tc0_rdata, tc1_rdata,
        output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
               s_addr, s_wdata, dm_byteen, tc0_we, tc1_we, bus_err
    );

    // Environment side (masters plus slaves).
    modport master (
        output m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata,
               m0_byteen, m1_byteen, dm_rdata, tc0_rdata, tc1_rdata,
        input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
               s_addr, s_wdata, dm_byteen, tc0_we, tc1_we, bus_err
    );
endinterface

// File: rtl/periph_addr_decode.sv
// Maps a byte address onto the DM, one of the two timers, or nothing.
module periph_addr_decode
    import periph_bus_arbiter_pkg::*;
(
    input  logic [31:0] addr,
    output tgt_e        tgt
);

    always_comb begin
        tgt = TGT_NONE;
        if (in_range(addr, DM_LO, DM_HI))
            tgt = TGT_DM;
        else if (in_range(addr, TC0_LO, TC0_HI))
            tgt = TGT_TC0;
        else if (in_range(addr, TC1_LO, TC1_HI))
            tgt = TGT_TC1;
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master (CPU, DMA) arbiter for the DM/timer peripheral bus with burst-limited ownership.
// Optional macro PERIPH_ARB_RR_EN: round-robin choice in IDLE instead of fixed M0 priority.
module periph_bus_arbiter
    import periph_bus_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    periph_bus_arbiter_if.slave  bus
);

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    arb_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d, cnt_inc;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_id_q, rd_id_d;
    tgt_e       rd_tgt_q, rd_tgt_d;
    logic       err_q, err_d;

    mreq_t [1:0] mreq;
    mreq_t       own;
    logic        own_id, other_req, any_req;
    logic        gnt0, gnt1, gnt, is_wr, pick, burst_done;
    arb_state_e  other_own;
    tgt_e        tgt;
    logic [31:0] rdata;

    assign mreq[0] = {bus.m0_req, bus.m0_addr, bus.m0_wdata, bus.m0_byteen};
    assign mreq[1] = {bus.m1_req, bus.m1_addr, bus.m1_wdata, bus.m1_byteen};

    assign own_id    = (state_q == OWN1);
    assign own       = mreq[own_id];
    assign other_req = mreq[~own_id].req;
    assign other_own = own_id ? OWN0 : OWN1;
    assign any_req   = mreq[0].req | mreq[1].req;

    assign gnt0  = (state_q == OWN0) && mreq[0].req;
    assign gnt1  = (state_q == OWN1) && mreq[1].req;
    assign gnt   = gnt0 | gnt1;
    assign is_wr = |own.byteen;

    periph_addr_decode u_dec (
        .addr (own.addr),
        .tgt  (tgt)
    );

`ifdef PERIPH_ARB_RR_EN
    // Last grantee; starts at 1 so M0 takes the first contested IDLE decision.
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (gnt)
            last_d = gnt1;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            last_q <= 1'b1;
        else
            last_q <= last_d;
    end

    assign pick = (mreq[0].req && mreq[1].req) ? ~last_q : mreq[1].req;
`else
    assign pick = mreq[1].req & ~mreq[0].req;
`endif

    // Saturating so a long uncontested burst cannot wrap back under the limit.
    assign cnt_inc    = (gnt && cnt_q != 4'hF) ? cnt_q + 4'd1 : cnt_q;
    assign burst_done = (cnt_inc >= BURST_LIM);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        case (state_q)
            IDLE: begin
                if (any_req)
                    state_d = pick ? OWN1 : OWN0;
            end
            OWN0, OWN1: begin
                if (!own.req)
                    state_d = other_req ? other_own : IDLE;
                else if (burst_done && other_req)
                    state_d = other_own;
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q)
            cnt_d = '0;
    end

    // Response bookkeeping survives an ownership switch because the id is registered.
    always_comb begin
        rd_pend_d = gnt && !is_wr;
        rd_id_d   = own_id;
        rd_tgt_d  = tgt;
        err_d     = gnt && (tgt == TGT_NONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_id_q   <= 1'b0;
            rd_tgt_q  <= TGT_NONE;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
            rd_tgt_q  <= rd_tgt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        case (rd_tgt_q)
            TGT_DM:  rdata = bus.dm_rdata;
            TGT_TC0: rdata = bus.tc0_rdata;
            TGT_TC1: rdata = bus.tc1_rdata;
            default: rdata = '0;
        endcase
    end

    // Every output is forced low while reset is held, including a response already in flight.
    logic rv0, rv1, drive;
    assign rv0   = reset & rd_pend_q & ~rd_id_q;
    assign rv1   = reset & rd_pend_q &  rd_id_q;
    assign drive = reset & gnt;

    assign bus.m0_gnt    = reset & gnt0;
    assign bus.m1_gnt    = reset & gnt1;
    assign bus.m0_rvalid = rv0;
    assign bus.m1_rvalid = rv1;
    assign bus.m0_rdata  = rv0 ? rdata : '0;
    assign bus.m1_rdata  = rv1 ? rdata : '0;
    assign bus.s_addr    = drive ? own.addr  : '0;
    assign bus.s_wdata   = drive ? own.wdata : '0;
    assign bus.dm_byteen = (drive && tgt == TGT_DM) ? own.byteen : '0;
    assign bus.tc0_we    = drive & is_wr & (tgt == TGT_TC0);
    assign bus.tc1_we    = drive & is_wr & (tgt == TGT_TC1);
    assign bus.bus_err   = reset & err_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Scoreboard bench for periph_bus_arbiter: grant and response expectations queued at drive time.
module tb_periph_bus_arbiter;

    localparam logic [31:0] TC0_VAL = 32'h7C00_00C0;
    localparam logic [31:0] TC1_VAL = 32'h7C11_11C1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    periph_bus_arbiter_if bus ();

    periph_bus_arbiter #(.MAX_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [71:0] gq[$];
    logic [66:0] rq[$];

    function automatic logic [31:0] dm_word(input logic [31:0] a);
        return (a == 32'h4) ? 32'h1234_5678 : {~a[15:0], a[15:0]};
    endfunction

    // 0 DM, 1 TC0, 2 TC1, 3 unmapped
    function automatic logic [1:0] tgt_of(input logic [31:0] a);
        if (a <= 32'h2FFF) return 2'd0;
        if (a >= 32'h7F00 && a <= 32'h7F0B) return 2'd1;
        if (a >= 32'h7F10 && a <= 32'h7F1B) return 2'd2;
        return 2'd3;
    endfunction

    // DM answers one cycle after its address; timers are combinational constants.
    always @(posedge clk) bus.dm_rdata <= dm_word(bus.s_addr);
    assign bus.tc0_rdata = TC0_VAL;
    assign bus.tc1_rdata = TC1_VAL;

    logic [71:0] gobs;
    logic [66:0] robs;
    assign gobs = {bus.m1_gnt, bus.m0_gnt, bus.s_addr, bus.s_wdata, bus.dm_byteen,
                   bus.tc0_we, bus.tc1_we};
    assign robs = {bus.m1_rvalid, bus.m0_rvalid, bus.bus_err, bus.m1_rdata, bus.m0_rdata};

    task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_xfer(input logic id, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, input logic want_rsp);
        logic [1:0]  t;
        logic [31:0] rd;
        logic        rv, err;
        t = tgt_of(a);
        gq.push_back({id, ~id, a, d, (t == 2'd0) ? be : 4'h0,
                      (t == 2'd1) && (be != 0), (t == 2'd2) && (be != 0)});
        rv  = (be == 0);
        err = (t == 2'd3);
        case (t)
            2'd0:    rd = dm_word(a);
            2'd1:    rd = TC0_VAL;
            2'd2:    rd = TC1_VAL;
            default: rd = 32'h0;
        endcase
        if (!rv) rd = 32'h0;
        if (want_rsp && (rv || err))
            rq.push_back({id & rv, ~id & rv, err, id ? rd : 32'h0, id ? 32'h0 : rd});
    endtask

    task automatic set_m(input logic id, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        if (id) begin
            bus.m1_req = r; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_byteen = be;
        end else begin
            bus.m0_req = r; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_byteen = be;
        end
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.m0_gnt || bus.m1_gnt) && n < 20);
    endtask

    // Single transfer from IDLE: arbitration cycle, grant cycle, then response cycle.
    task automatic xfer(input logic id, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be);
        int n;
        push_xfer(id, a, d, be, 1'b1);
        @(posedge clk); #1;
        set_m(id, 1'b1, a, d, be);
        wait_gnt(n);
        chk("gnt_lat", n, 2);
        @(posedge clk); #1;
        set_m(id, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("rsp_lat", (id ? bus.m1_rvalid : bus.m0_rvalid) | bus.bus_err,
            (be == 0) || (tgt_of(a) == 2'd3));
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // Scoreboard: every grant and every response/error must match the head of its queue.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.m0_gnt || bus.m1_gnt) begin
                if (gq.size() == 0) chk("gnt_unexpected", gobs, 0);
                else                chk("gnt", gobs, gq.pop_front());
            end
            if (bus.m0_rvalid || bus.m1_rvalid || bus.bus_err) begin
                if (rq.size() == 0) chk("rsp_unexpected", robs, 0);
                else                chk("rsp", robs, rq.pop_front());
            end
        end
    end

    initial begin
        int n, g, cyc;
        logic w;
        set_m(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_outs", {gobs, robs}, 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;

        xfer(1'b0, 32'h0000_0004, 32'h0,         4'h0);
        xfer(1'b0, 32'h0000_7F04, 32'hA5,        4'hF);
        xfer(1'b1, 32'h0000_5000, 32'h0,         4'h0);
        xfer(1'b0, 32'h0000_2FFC, 32'h1122_3344, 4'h3);
        xfer(1'b1, 32'h0000_3000, 32'h0,         4'h0);
        xfer(1'b0, 32'h0000_7F0C, 32'h55,        4'h1);
        xfer(1'b1, 32'h0000_7F10, 32'h77,        4'h2);
        xfer(1'b0, 32'h0000_7F1B, 32'h0,         4'h0);
        xfer(1'b1, 32'h0000_7F08, 32'h0,         4'h0);

        // Continuous contention: 4 + 4 grants repeating, no gap between bursts.
        pulse_reset();
        for (int k = 0; k < 16; k++) begin
            w = k[2];
            push_xfer(w, w ? 32'h200 : 32'h100, 32'h0, 4'h0, 1'b1);
        end
        @(posedge clk); #1;
        set_m(1'b0, 1'b1, 32'h100, 32'h0, 4'h0);
        set_m(1'b1, 1'b1, 32'h200, 32'h0, 4'h0);
        wait_gnt(n);
        chk("burst_lat", n, 2);
        g = 1;
        cyc = 0;
        while (g < 16 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.m0_gnt || bus.m1_gnt) g++;
        end
        chk("burst_gapless", cyc, 15);
        @(posedge clk); #1;
        set_m(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);

        // Simultaneous requests from IDLE, both dropped after each transfer.
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
`ifdef PERIPH_ARB_RR_EN
            w = i[0];
`else
            w = 1'b0;
`endif
            push_xfer(w, w ? 32'h80 : 32'h40, 32'h0, 4'h0, 1'b1);
            @(posedge clk); #1;
            set_m(1'b0, 1'b1, 32'h40, 32'h0, 4'h0);
            set_m(1'b1, 1'b1, 32'h80, 32'h0, 4'h0);
            wait_gnt(n);
            chk("rr_winner", {bus.m1_gnt, bus.m0_gnt}, {w, ~w});
            @(posedge clk); #1;
            set_m(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            set_m(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
            repeat (3) @(negedge clk);
        end

        // Reset right after an accepted DM read: its response must never appear.
        push_xfer(1'b0, 32'h8, 32'h0, 4'h0, 1'b0);
        @(posedge clk); #1;
        set_m(1'b0, 1'b1, 32'h8, 32'h0, 4'h0);
        wait_gnt(n);
        chk("mid_gnt_lat", n, 2);
        @(posedge clk); #1;
        set_m(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_outs", {gobs, robs}, 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        xfer(1'b1, 32'h0000_7F18, 32'h0, 4'h0);

        repeat (2) @(negedge clk);
        chk("gq_left", gq.size(), 0);
        chk("rq_left", rq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
